// File: rtl/apb_mem_responder.sv
// APB3 completer exposing a word-addressed scratch memory and a small register bank
// (ID, SCRATCH, transfer counters) with a configurable number of wait states.
module apb_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4D454D31
) (
  input  logic        PCLK,
  input  logic        PRESET_N,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [15:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  // Handshake: a transfer starts with a setup phase (PSEL=1, PENABLE=0) seen in IDLE,
  // and completes in the single cycle where PREADY=1; PSLVERR/PRDATA are meaningful
  // only in that cycle. Dropping PSEL before completion abandons the transfer.

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [16:0] MEM_BYTES  = 17'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WCNT_INIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] scratch_q, scratch_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [15:0]   cur_addr;
  logic          cur_write;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] mem_idx;
  logic          in_mem, is_id, is_scr, is_wrc, is_rdc, is_errc, err;
  logic [31:0]   rd_val;
  logic          commit, mem_we;

  // In IDLE the live bus is the transfer (zero-wait completes on the setup edge);
  // afterwards the captured setup-phase values are used.
  always_comb begin
    cur_addr  = (state_q == IDLE) ? PADDR  : addr_q;
    cur_write = (state_q == IDLE) ? PWRITE : write_q;
    cur_wdata = (state_q == IDLE) ? PWDATA : wdata_q;
  end

  always_comb begin
    in_mem  = {1'b0, cur_addr} < MEM_BYTES;
    is_id   = cur_addr == 16'h8000;
    is_scr  = cur_addr == 16'h8004;
    is_wrc  = cur_addr == 16'h8008;
    is_rdc  = cur_addr == 16'h800C;
    is_errc = cur_addr == 16'h8010;
    mem_idx = cur_addr[AW+1:2];
    err     = (cur_addr[1:0] != 2'b00)
            || !(in_mem || is_id || is_scr || is_wrc || is_rdc || is_errc)
            || (cur_write && (is_id || is_wrc || is_rdc));
    rd_val  = 32'h0;
    if (in_mem)       rd_val = mem[mem_idx];
    else if (is_id)   rd_val = ID_VALUE;
    else if (is_scr)  rd_val = scratch_q;
    else if (is_wrc)  rd_val = {16'h0, wr_cnt_q};
    else if (is_rdc)  rd_val = {16'h0, rd_cnt_q};
    else if (is_errc) rd_val = {24'h0, err_cnt_q};
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          wcnt_d  = WCNT_INIT;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (wcnt_q <= 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    scratch_d = scratch_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    mem_we    = 1'b0;
    if (commit) begin
      pready_d  = 1'b1;
      pslverr_d = err;
      prdata_d  = (!err && !cur_write) ? rd_val : 32'h0;
      if (err) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else if (cur_write) begin
        if (in_mem) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (is_scr)  scratch_d = cur_wdata;
        if (is_errc) err_cnt_d = 8'h0;
      end else if (in_mem) begin
        rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'h0;
      addr_q    <= 16'h0;
      write_q   <= 1'b0;
      wdata_q   <= 32'h0;
      scratch_q <= 32'h0;
      wr_cnt_q  <= 16'h0;
      rd_cnt_q  <= 16'h0;
      err_cnt_q <= 8'h0;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      scratch_q <= scratch_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge PCLK) begin
    if (mem_we) mem[mem_idx] <= cur_wdata;
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_responder.sv
// Randomized scoreboard bench: three responders (WAIT_STATES 1, 0, 3) checked against
// a behavioural model of the memory window and register bank.
module tb_apb_mem_responder;

  localparam int DEPTH = 256;
  localparam int NDUT  = 3;
  localparam int W     = 33;

  logic clk = 1'b0;
  logic rst_n;
  logic [NDUT-1:0]       psel, penable, pwrite;
  logic [NDUT-1:0][15:0] paddr;
  logic [NDUT-1:0][31:0] pwdata;
  wire  [NDUT-1:0][31:0] prdata;
  wire  [NDUT-1:0]       pready, pslverr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .ID_VALUE(32'h4D454D31)
    ) u_dut (
      .PCLK(clk), .PRESET_N(rst_n), .PSEL(psel[g]), .PENABLE(penable[g]),
      .PWRITE(pwrite[g]), .PADDR(paddr[g]), .PWDATA(pwdata[g]),
      .PRDATA(prdata[g]), .PREADY(pready[g]), .PSLVERR(pslverr[g])
    );
  end

  // Expected response per completed transfer: {pslverr, prdata}.
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem   [NDUT][DEPTH];
  bit          m_valid [NDUT][DEPTH];
  logic [31:0] m_scr   [NDUT];
  int          m_wr    [NDUT];
  int          m_rd    [NDUT];
  int          m_err   [NDUT];

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_scr[d] = 32'h0;
      m_wr[d]  = 0;
      m_rd[d]  = 0;
      m_err[d] = 0;
    end
  endtask

  // Applies one transfer to the model and returns what the completer must answer.
  task automatic model_xfer(input int d, input bit wr, input logic [15:0] a,
                            input logic [31:0] wd, output logic [W-1:0] r);
    bit is_mem, mapped, ro, e;
    logic [31:0] data;
    is_mem = int'(a) < DEPTH * 4;
    mapped = is_mem || (a inside {16'h8000, 16'h8004, 16'h8008, 16'h800C, 16'h8010});
    ro     = a inside {16'h8000, 16'h8008, 16'h800C};
    e      = (int'(a) % 4 != 0) || !mapped || (wr && ro);
    data   = 32'h0;
    if (e) begin
      m_err[d] = (m_err[d] >= 255) ? 255 : m_err[d] + 1;
    end else if (wr) begin
      if (is_mem) begin
        m_mem[d][int'(a) / 4]   = wd;
        m_valid[d][int'(a) / 4] = 1'b1;
        m_wr[d] = (m_wr[d] + 1) % 65536;
      end else if (a == 16'h8004) begin
        m_scr[d] = wd;
      end else if (a == 16'h8010) begin
        m_err[d] = 0;
      end
    end else begin
      if (is_mem) begin
        data    = m_mem[d][int'(a) / 4];
        m_rd[d] = (m_rd[d] + 1) % 65536;
      end else begin
        case (a)
          16'h8000: data = 32'h4D454D31;
          16'h8004: data = m_scr[d];
          16'h8008: data = 32'(m_wr[d]);
          16'h800C: data = 32'(m_rd[d]);
          default:  data = 32'(m_err[d]);
        endcase
      end
    end
    r = {e, data};
  endtask

  // Entered and left at posedge+1; a following call starts its setup phase
  // in the very next cycle.
  task automatic xfer(input int d, input bit wr, input logic [15:0] a, input logic [31:0] wd);
    logic [W-1:0] r;
    int  acc;
    bit  done;
    model_xfer(d, wr, a, wd, r);
    exp_q.push_back(r);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    acc  = 1;
    done = 1'b0;
    while (!done && acc <= 40) begin
      @(negedge clk);
      if (pready[d]) done = 1'b1;
      else begin
        @(posedge clk); #1;
        acc++;
      end
    end
    checks++;
    if (!done || acc != ws_of(d) + 1) begin
      errors++;
      $display("FAIL latency dut%0d addr %h: access cycles %0d done %0d expected %0d",
               d, a, acc, done, ws_of(d) + 1);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_xfer(input int d);
    int k, w, start;
    logic [15:0] a;
    k = $urandom_range(0, 9);
    w = $urandom_range(0, DEPTH - 1);
    case (k)
      0, 1, 2: xfer(d, 1'b1, 16'(w * 4), $urandom);
      3, 4: begin
        start = w;
        w = -1;
        for (int i = 0; i < DEPTH; i++)
          if (w < 0 && m_valid[d][(start + i) % DEPTH]) w = (start + i) % DEPTH;
        if (w < 0) xfer(d, 1'b1, 16'(start * 4), $urandom);
        else       xfer(d, 1'b0, 16'(w * 4), 32'h0);
      end
      5: xfer(d, $urandom_range(0, 1) == 1, 16'h8004, $urandom);
      6: xfer(d, 1'b0, 16'h8000 + 16'($urandom_range(0, 4) * 4), 32'h0);
      7: xfer(d, 1'b1, 16'h8000 + 16'($urandom_range(0, 3) * 4), $urandom);
      8: xfer(d, $urandom_range(0, 1) == 1, 16'(w * 4 + $urandom_range(1, 3)), $urandom);
      default: begin
        if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(DEPTH, 16'h1FFF) * 4);
        else                           a = 16'h8014 + 16'($urandom_range(0, 100) * 4);
        xfer(d, $urandom_range(0, 1) == 1, a, $urandom);
      end
    endcase
  endtask

  // Monitor: every PREADY pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    for (int d = 0; d < NDUT; d++) begin
      if (rst_n && pready[d]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pready dut%0d: prdata %h pslverr %0b with nothing outstanding",
                   d, prdata[d], pslverr[d]);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("pslverr dut%0d", d), 32'(pslverr[d]), 32'(e[32]));
          check($sformatf("prdata dut%0d", d), prdata[d], e[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] dummy;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < DEPTH; i++) m_valid[d][i] = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_pready dut%0d", d), 32'(pready[d]), 32'h0);
      check($sformatf("reset_pslverr dut%0d", d), 32'(pslverr[d]), 32'h0);
      check($sformatf("reset_prdata dut%0d", d), prdata[d], 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // One wait state: write then read back, counters follow.
    xfer(0, 1'b1, 16'h0010, 32'hDEADBEEF);
    xfer(0, 1'b0, 16'h0010, 32'h0);
    xfer(0, 1'b0, 16'h8008, 32'h0);
    xfer(0, 1'b0, 16'h800C, 32'h0);
    xfer(0, 1'b0, 16'h8004, 32'h0);
    // Error cases, then error count and ID intact.
    xfer(0, 1'b0, 16'h0402, 32'h0);
    xfer(0, 1'b0, 16'h0400, 32'h0);
    xfer(0, 1'b1, 16'h8000, 32'h12345678);
    xfer(0, 1'b0, 16'h8010, 32'h0);
    xfer(0, 1'b0, 16'h8000, 32'h0);

    // Zero wait states, back-to-back with no idle cycles, including the last word.
    xfer(1, 1'b1, 16'h0000, 32'h01234567);
    xfer(1, 1'b1, 16'h03FC, 32'h89ABCDEF);
    xfer(1, 1'b0, 16'h0000, 32'h0);
    xfer(1, 1'b0, 16'h03FC, 32'h0);
    xfer(1, 1'b1, 16'h0000, 32'hCAFEF00D);
    xfer(1, 1'b0, 16'h0000, 32'h0);
    // Error counter saturation and clear.
    for (int i = 0; i < 260; i++) begin
      case ($urandom_range(0, 2))
        0:       xfer(1, 1'b0, 16'(($urandom_range(0, DEPTH - 1) * 4) + 2), 32'h0);
        1:       xfer(1, 1'b0, 16'h0400 + 16'($urandom_range(0, 255) * 4), 32'h0);
        default: xfer(1, 1'b1, 16'h8000, $urandom);
      endcase
    end
    xfer(1, 1'b0, 16'h8010, 32'h0);
    xfer(1, 1'b1, 16'h8010, $urandom);
    xfer(1, 1'b0, 16'h8010, 32'h0);

    // Three wait states: a write abandoned mid-access has no effect.
    xfer(2, 1'b1, 16'h0020, 32'h11112222);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 16'h0020; pwdata[2] = 32'h33334444;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    idle(5);
    xfer(2, 1'b0, 16'h0020, 32'h0);
    xfer(2, 1'b0, 16'h8008, 32'h0);

    for (int n = 0; n < 40; n++)
      for (int d = 0; d < NDUT; d++) begin
        rand_xfer(d);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

    // Reset while a write sits in its wait states.
    xfer(2, 1'b1, 16'h0040, 32'hA5A50040);
    xfer(2, 1'b1, 16'h8004, 32'h00001234);
    xfer(2, 1'b0, 16'h8004, 32'h0);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 16'h0040; pwdata[2] = 32'h0BAD0BAD;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("midreset_pready", 32'(pready[2]), 32'h0);
    check("midreset_prdata", prdata[2], 32'h0);
    check("midreset_pslverr", 32'(pslverr[2]), 32'h0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 16'h8004, 32'h0);
    xfer(2, 1'b0, 16'h0040, 32'h0);
    xfer(2, 1'b1, 16'h0044, 32'h5A5A0044);
    xfer(2, 1'b0, 16'h0044, 32'h0);
    xfer(2, 1'b0, 16'h8008, 32'h0);

    idle(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding: %0d responses never seen, expected 0", exp_q.size());
    end
    dummy = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
